// File: rtl/exe_muldiv_unit.sv
// Multi-cycle multiply/divide unit for the or1420 execute stage.
// Fixed-latency multiply, radix-2 restoring divide, busy/done handshake with stall hold.
module exe_muldiv_unit #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic                  cpuClock,
  input  logic                  cpuReset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  start,
  input  logic [2:0]            opcode,
  input  logic [DATA_WIDTH-1:0] operantA,
  input  logic [DATA_WIDTH-1:0] operantB,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  divByZero
);

  localparam int unsigned W      = DATA_WIDTH;
  localparam int unsigned MUL_CW = $clog2(MUL_LATENCY + 1);
  localparam int unsigned DIV_CW = $clog2(W);
  localparam int unsigned CNT_W  = (MUL_CW > DIV_CW) ? MUL_CW : DIV_CW;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_op;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_quo;
  logic [W-1:0]       r_rem;
  logic [W-1:0]       r_dvs;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_busy;
  logic               r_done;
  logic [W-1:0]       r_result;
  logic               r_dbz;

  logic               w_accept;
  logic               w_dbz_in;
  logic               w_rsv_in;
  logic               w_dsgn;
  logic [W-1:0]       w_abs_a;
  logic [W-1:0]       w_abs_b;
  logic [2:0]         w_mop;
  logic [W-1:0]       w_ma;
  logic [W-1:0]       w_mb;
  logic               w_msgn;
  logic [2*W-1:0]     w_pa;
  logic [2*W-1:0]     w_pb;
  logic [2*W-1:0]     w_prod;
  logic [W-1:0]       w_mul_res;
  logic [W:0]         w_rem_sh;
  logic [W:0]         w_trial;
  logic               w_qbit;
  logic [W-1:0]       w_rem_nxt;
  logic [W-1:0]       w_fix_res;
  logic               w_busy_nxt;
  logic               w_done_nxt;

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign divByZero = r_dbz;

  // Issue decode and operand magnitudes for the divider
  assign w_accept = (r_state == S_IDLE) && start && !flush;
  assign w_dbz_in = opcode[2] && (operantB == '0);
  assign w_rsv_in = (opcode == 3'b011);
  assign w_dsgn   = opcode[2] && !opcode[0];
  assign w_abs_a  = (w_dsgn && operantA[W-1]) ? W'(-operantA) : operantA;
  assign w_abs_b  = (w_dsgn && operantB[W-1]) ? W'(-operantB) : operantB;

  // Multiplier reads live inputs when finishing straight from IDLE (MUL_LATENCY=1)
  assign w_mop     = (r_state == S_IDLE) ? opcode   : r_op;
  assign w_ma      = (r_state == S_IDLE) ? operantA : r_a;
  assign w_mb      = (r_state == S_IDLE) ? operantB : r_b;
  assign w_msgn    = (w_mop == 3'b001);
  assign w_pa      = {{W{w_msgn & w_ma[W-1]}}, w_ma};
  assign w_pb      = {{W{w_msgn & w_mb[W-1]}}, w_mb};
  assign w_prod    = w_pa * w_pb;
  assign w_mul_res = (w_mop == 3'b000) ? w_prod[W-1:0] : w_prod[2*W-1:W];

  // One restoring-division step: shift in next dividend bit, trial subtract
  assign w_rem_sh  = {r_rem, r_quo[W-1]};
  assign w_trial   = w_rem_sh - {1'b0, r_dvs};
  assign w_qbit    = !w_trial[W];
  assign w_rem_nxt = w_qbit ? w_trial[W-1:0] : w_rem_sh[W-1:0];

  assign w_fix_res = r_op[1] ? (r_neg_r ? W'(-r_rem) : r_rem)
                             : (r_neg_q ? W'(-r_quo) : r_quo);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (opcode[2])     w_next = w_dbz_in ? S_DONE : S_DIV;
          else if (w_rsv_in) w_next = S_DONE;
          else               w_next = (MUL_LATENCY == 1) ? S_DONE : S_MUL;
        end
      end
      S_MUL:   if (r_cnt == CNT_W'(1)) w_next = S_DONE;
      S_DIV:   if (r_cnt == '0) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  if (!stall) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
    w_busy_nxt = (w_next == S_MUL) || (w_next == S_DIV) || (w_next == S_FIX);
    w_done_nxt = (w_next == S_DONE);
  end

  always_ff @(posedge cpuClock) begin
    if (cpuReset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_dbz    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) begin
        r_op    <= opcode;
        r_a     <= operantA;
        r_b     <= operantB;
        r_quo   <= w_abs_a;
        r_dvs   <= w_abs_b;
        r_rem   <= '0;
        r_neg_q <= w_dsgn && (operantA[W-1] ^ operantB[W-1]);
        r_neg_r <= w_dsgn && operantA[W-1];
        r_dbz   <= w_dbz_in;
        r_cnt   <= opcode[2] ? CNT_W'(W - 1) : CNT_W'(MUL_LATENCY - 1);
        if (w_next == S_DONE) begin
          if (w_dbz_in)      r_result <= opcode[1] ? operantA : '1;
          else if (w_rsv_in) r_result <= '0;
          else               r_result <= w_mul_res;
        end
      end else begin
        case (r_state)
          S_MUL: begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_next == S_DONE) r_result <= w_mul_res;
          end
          S_DIV: begin
            r_rem <= w_rem_nxt;
            r_quo <= {r_quo[W-2:0], w_qbit};
            r_cnt <= r_cnt - CNT_W'(1);
          end
          S_FIX: begin
            if (w_next == S_DONE) r_result <= w_fix_res;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed-vector bench for exe_muldiv_unit (DATA_WIDTH=32, MUL_LATENCY=3).
module tb_exe_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        start;
  logic [2:0]  opcode;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        divByZero;

  int n_vec = 0;
  int n_err = 0;

  exe_muldiv_unit #(.DATA_WIDTH(32), .MUL_LATENCY(3)) dut (
    .cpuClock (clk),
    .cpuReset (rst),
    .stall    (stall),
    .flush    (flush),
    .start    (start),
    .opcode   (opcode),
    .operantA (opA),
    .operantB (opB),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .divByZero(divByZero)
  );

  always #5 clk = ~clk;

  // Issue one op and wait (bounded) for done; steps back to IDLE unless stalled
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output logic [31:0] res, output logic dz);
    @(negedge clk);
    opcode = op; opA = a; opB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    res = result;
    dz  = divByZero;
    if (stall == 1'b0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_vec++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got=%h exp=0", result); end
    n_vec++; if (divByZero !== 1'b0) begin n_err++; $display("FAIL reset_dbz got=%b exp=0", divByZero); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul;
    int cyc; logic [31:0] r; logic dz;
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, cyc, r, dz);
    n_vec++; if (cyc !== 3) begin n_err++; $display("FAIL mullo_latency got=%0d exp=3", cyc); end
    n_vec++; if (r !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mullo_result got=%h exp=ffffffeb", r); end
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, r, dz);
    n_vec++; if (r !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mulhuu_result got=%h exp=fffffffe", r); end
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, r, dz);
    n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL mulhss_m1m1 got=%h exp=00000000", r); end
    run_op(3'b001, 32'h8000_0000, 32'd2, cyc, r, dz);
    n_vec++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mulhss_min2 got=%h exp=ffffffff", r); end
    run_op(3'b011, 32'd9, 32'd9, cyc, r, dz);
    n_vec++; if (cyc !== 1 || r !== 32'h0) begin
      n_err++; $display("FAIL reserved_op got cyc=%0d res=%h exp cyc=1 res=0", cyc, r);
    end
  endtask

  task automatic test_div;
    int cyc; logic [31:0] r; logic dz;
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, cyc, r, dz);
    n_vec++; if (cyc !== 34) begin n_err++; $display("FAIL divs_latency got=%0d exp=34", cyc); end
    n_vec++; if (r !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL divs_result got=%h exp=fffffffd", r); end
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, cyc, r, dz);
    n_vec++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rems_result got=%h exp=ffffffff", r); end
    run_op(3'b101, 32'd100, 32'd7, cyc, r, dz);
    n_vec++; if (r !== 32'd14) begin n_err++; $display("FAIL divu_result got=%h exp=0000000e", r); end
    run_op(3'b111, 32'd100, 32'd7, cyc, r, dz);
    n_vec++; if (r !== 32'd2) begin n_err++; $display("FAIL remu_result got=%h exp=00000002", r); end
    run_op(3'b110, 32'd7, 32'hFFFF_FFFE, cyc, r, dz);
    n_vec++; if (r !== 32'd1) begin n_err++; $display("FAIL rems_posneg got=%h exp=00000001", r); end
  endtask

  task automatic test_divzero;
    int cyc; logic [31:0] r; logic dz;
    run_op(3'b101, 32'd5, 32'd0, cyc, r, dz);
    n_vec++; if (cyc !== 1) begin n_err++; $display("FAIL dbz_latency got=%0d exp=1", cyc); end
    n_vec++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL dbz_quot got=%h exp=ffffffff", r); end
    n_vec++; if (dz !== 1'b1) begin n_err++; $display("FAIL dbz_flag got=%b exp=1", dz); end
    run_op(3'b111, 32'd5, 32'd0, cyc, r, dz);
    n_vec++; if (r !== 32'd5 || dz !== 1'b1) begin
      n_err++; $display("FAIL dbz_rem got res=%h dbz=%b exp res=5 dbz=1", r, dz);
    end
  endtask

  task automatic test_overflow;
    int cyc; logic [31:0] r; logic dz;
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, cyc, r, dz);
    n_vec++; if (r !== 32'h8000_0000) begin n_err++; $display("FAIL ovf_quot got=%h exp=80000000", r); end
    n_vec++; if (dz !== 1'b0) begin n_err++; $display("FAIL ovf_dbz got=%b exp=0", dz); end
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, cyc, r, dz);
    n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL ovf_rem got=%h exp=00000000", r); end
  endtask

  task automatic test_stall;
    int cyc; logic [31:0] r; logic dz;
    stall = 1'b1;
    run_op(3'b000, 32'd3, 32'd5, cyc, r, dz);
    n_vec++; if (r !== 32'd15) begin n_err++; $display("FAIL stall_result got=%h exp=0000000f", r); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_vec++; if (done !== 1'b1 || result !== 32'd15) begin
        n_err++; $display("FAIL stall_hold%0d got done=%b res=%h exp done=1 res=f", i, done, result);
      end
    end
    @(negedge clk);
    stall = 1'b0; start = 1'b1; opcode = 3'b000; opA = 32'd2; opB = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL stall_release got done=%b busy=%b exp 0 0", done, busy);
    end
    @(posedge clk); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL start_on_release got busy=%b exp=0", busy); end
    run_op(3'b000, 32'd2, 32'd3, cyc, r, dz);
    n_vec++; if (r !== 32'd6 || cyc !== 3) begin
      n_err++; $display("FAIL after_release got res=%h cyc=%0d exp res=6 cyc=3", r, cyc);
    end
  endtask

  task automatic test_flush;
    int cyc; logic [31:0] r; logic dz; bit seen;
    @(negedge clk);
    opcode = 3'b101; opA = 32'd100; opB = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_pre_busy got=%b exp=1", busy); end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL flush_idle got busy=%b done=%b exp 0 0", busy, done);
    end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1) seen = 1'b1; end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_no_done got seen=%b exp=0", seen); end
    @(negedge clk);
    flush = 1'b1; start = 1'b1; opcode = 3'b000;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL flush_blocks_start got busy=%b done=%b exp 0 0", busy, done);
    end
    run_op(3'b101, 32'd100, 32'd7, cyc, r, dz);
    n_vec++; if (r !== 32'd14 || cyc !== 34) begin
      n_err++; $display("FAIL post_flush_div got res=%h cyc=%0d exp res=e cyc=34", r, cyc);
    end
  endtask

  task automatic test_reset_midop;
    @(negedge clk);
    opcode = 3'b100; opA = 32'd50; opB = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++; if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || divByZero !== 1'b0) begin
      n_err++; $display("FAIL reset_midop got busy=%b done=%b res=%h dbz=%b exp all 0",
                        busy, done, result, divByZero);
    end
    seen_check: begin
      bit seen;
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) seen = 1'b1; end
      n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL reset_midop_quiet got=%b exp=0", seen); end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; start = 1'b0;
    opcode = 3'b000; opA = '0; opB = '0;
    test_reset();
    test_mul();
    test_div();
    test_divzero();
    test_overflow();
    test_stall();
    test_flush();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
